sifreleme_birimi: RTL and testbench

- Single-cycle bit-manipulation ("encryption") execute unit in the core's execute stage.
- Selects one of six operations on two 32-bit operands: Hamming distance, pack, byte reverse, shift-left-add, count trailing zeros, population count.
- The result is registered, giving one clock of latency, and is qualified by a valid strobe.

---
 rtl/sifreleme_birimi_pkg.sv | 9 +
 rtl/sifreleme_birimi_bit_sayici.sv | 10 +
 rtl/sifreleme_birimi.sv | 44 ++++
 tb/tb_sifreleme_birimi.sv | 131 +++++++++++++
 4 files changed

// File: rtl/sifreleme_birimi_pkg.sv
// sifreleme_birimi_pkg: operation codes shared by the encryption unit and the decoder
package sifreleme_birimi_pkg;
  localparam logic [2:0] SIFRELEME_HMDST = 3'd0;
  localparam logic [2:0] SIFRELEME_PKG   = 3'd1;
  localparam logic [2:0] SIFRELEME_RVRS  = 3'd2;
  localparam logic [2:0] SIFRELEME_SLADD = 3'd3;
  localparam logic [2:0] SIFRELEME_CNTZ  = 3'd4;
  localparam logic [2:0] SIFRELEME_CNTP  = 3'd5;
endpackage

// File: rtl/sifreleme_birimi_bit_sayici.sv
// bit_sayici: 32-bit combinational population counter
module bit_sayici (
  input  logic [31:0] veri,
  output logic [5:0]  sayi
);
  always_comb begin
    sayi = '0;
    for (int i = 0; i < 32; i++) sayi = sayi + {5'd0, veri[i]};
  end
endmodule

// File: rtl/sifreleme_birimi.sv
// sifreleme_birimi: single-cycle bit-manipulation execute unit with a registered result
module sifreleme_birimi
  import sifreleme_birimi_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        gecerli_i,
  input  logic [2:0]  kontrol_i,
  input  logic [31:0] deger1_i,
  input  logic [31:0] deger2_i,
  output logic [31:0] sonuc_o,
  output logic        gecerli_o
);
  logic [31:0] sayac_giris;
  logic [5:0]  bir_sayisi;
  logic [5:0]  sifir_sayisi;
  logic [31:0] sonuc_d;
  // one shared popcount: a^b for Hamming distance, a alone otherwise so b cannot leak into CNTP
  assign sayac_giris = (kontrol_i == SIFRELEME_HMDST) ? deger1_i ^ deger2_i : deger1_i;
  bit_sayici u_bit_sayici (
    .veri(sayac_giris),
    .sayi(bir_sayisi)
  );
  always_comb begin
    sifir_sayisi = 6'd32;
    for (int i = 31; i >= 0; i--) if (deger1_i[i]) sifir_sayisi = 6'(i);
  end
  always_comb begin
    sonuc_d = (kontrol_i == SIFRELEME_HMDST || kontrol_i == SIFRELEME_CNTP) ? {26'd0, bir_sayisi} :
              (kontrol_i == SIFRELEME_PKG)   ? {deger2_i[15:0], deger1_i[15:0]} :
              (kontrol_i == SIFRELEME_RVRS)  ? {deger1_i[7:0], deger1_i[15:8], deger1_i[23:16], deger1_i[31:24]} :
              (kontrol_i == SIFRELEME_SLADD) ? {deger1_i[30:0], 1'b0} + deger2_i :
              (kontrol_i == SIFRELEME_CNTZ)  ? {26'd0, sifir_sayisi} : 32'h0;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sonuc_o   <= '0;
      gecerli_o <= 1'b0;
    end else begin
      gecerli_o <= gecerli_i;
      if (gecerli_i) sonuc_o <= sonuc_d;
    end
  end
endmodule

// File: tb/tb_sifreleme_birimi.sv
// tb_sifreleme_birimi: directed and randomized checks against a behavioural model
module tb_sifreleme_birimi;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        gecerli_i = 1'b0;
  logic [2:0]  kontrol_i = '0;
  logic [31:0] deger1_i = '0;
  logic [31:0] deger2_i = '0;
  logic [31:0] sonuc_o;
  logic        gecerli_o;
  int checks = 0;
  int failures = 0;
  logic [31:0] tutulan = '0;
  sifreleme_birimi dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .gecerli_i(gecerli_i),
    .kontrol_i(kontrol_i),
    .deger1_i(deger1_i),
    .deger2_i(deger2_i),
    .sonuc_o(sonuc_o),
    .gecerli_o(gecerli_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic kontrol_et(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    int n;
    case (op)
      3'd0: return 32'($countones(a ^ b));
      3'd1: return (b << 16) | (a & 32'h0000_FFFF);
      3'd2: begin
        for (int k = 0; k < 4; k++) r[8*k +: 8] = a[8*(3-k) +: 8];
        return r;
      end
      3'd3: return a * 2 + b;
      3'd4: begin
        n = 0;
        while (n < 32 && a[n] == 1'b0) n++;
        return 32'(n);
      end
      3'd5: return 32'($countones(a));
      default: return 32'h0;
    endcase
  endfunction
  task automatic istek(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    @(negedge clk_i);
    gecerli_i = 1'b1;
    kontrol_i = op;
    deger1_i  = a;
    deger2_i  = b;
    @(posedge clk_i);
    #1;
    kontrol_et({tag, "_gecerli"}, {31'd0, gecerli_o}, 32'd1);
    kontrol_et(tag, sonuc_o, exp);
    tutulan = exp;
  endtask
  task automatic bos(input string tag);
    @(negedge clk_i);
    gecerli_i = 1'b0;
    kontrol_i = 3'($urandom_range(0, 7));
    deger1_i  = $urandom;
    deger2_i  = $urandom;
    @(posedge clk_i);
    #1;
    kontrol_et({tag, "_gecerli"}, {31'd0, gecerli_o}, 32'd0);
    kontrol_et({tag, "_tut"}, sonuc_o, tutulan);
  endtask
  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    #12;
    kontrol_et("rst_sonuc", sonuc_o, 32'h0);
    kontrol_et("rst_gecerli", {31'd0, gecerli_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    istek("hmdst", 3'd0, 32'hF0F0_F0F0, 32'hFFF0_F0F0, 32'd4);
    istek("hmdst_esit", 3'd0, 32'h1234_ABCD, 32'h1234_ABCD, 32'd0);
    istek("hmdst_ters", 3'd0, 32'h5A5A_0FF0, ~32'h5A5A_0FF0, 32'd32);
    istek("pkg", 3'd1, 32'hFFFF_000F, 32'hFFFF_0F0F, 32'h0F0F_000F);
    istek("rvrs1", 3'd2, 32'hFFFF_0000, 32'hDEAD_BEEF, 32'h0000_FFFF);
    istek("rvrs2", 3'd2, 32'h1234_5678, 32'h0, 32'h7856_3412);
    istek("sladd", 3'd3, 32'd16, 32'd38, 32'd70);
    istek("sladd_tas", 3'd3, 32'h8000_0001, 32'hFFFF_FFFF, 32'h0000_0001);
    istek("cntz16", 3'd4, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'd16);
    istek("cntz_sifir", 3'd4, 32'h0, 32'h1234_5678, 32'd32);
    istek("cntz_bir", 3'd4, 32'h1, 32'h0, 32'd0);
    istek("cntp4", 3'd5, 32'hF000_0000, 32'hFFFF_FFFF, 32'd4);
    istek("cntp32", 3'd5, 32'hFFFF_FFFF, 32'h0, 32'd32);
    istek("rezerve7", 3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    istek("rezerve6", 3'd6, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0);
    bos("bos1");
    bos("bos2");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) bos("r_bos");
      else begin
        op = 3'($urandom_range(0, 7));
        a = $urandom;
        b = $urandom;
        case ($urandom_range(0, 5))
          0: a = 32'h0;
          1: a = 32'h1 << $urandom_range(0, 31);
          2: b = ~a;
          default: ;
        endcase
        istek($sformatf("r_op%0d", op), op, a, b, model(op, a, b));
      end
    end
    istek("rst_once", 3'd2, 32'hA1B2_C3D4, 32'h0, 32'hD4C3_B2A1);
    #2;
    rst_ni = 1'b0;
    #1;
    kontrol_et("rst_ani_sonuc", sonuc_o, 32'h0);
    kontrol_et("rst_ani_gecerli", {31'd0, gecerli_o}, 32'd0);
    @(negedge clk_i);
    gecerli_i = 1'b0;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    kontrol_et("rst_sonra_gecerli", {31'd0, gecerli_o}, 32'd0);
    kontrol_et("rst_sonra_sonuc", sonuc_o, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
